// File: rtl/reglk_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reglk_guard_pkg
// Description : Shared types and helpers for the register-lock write guard.
//               - state_e          : guard transaction state
//               - c_deny_rdata_bit : fill bit for read data on a denied write
//               - lock_hit()       : lock decision for a register index
// Revision    : 1.0 - initial release
// ============================================================================
package reglk_guard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2,
    DENY = 2'd3
  } state_e;

  // Denied writes return all-zero read data.
  localparam logic c_deny_rdata_bit = 1'b0;

  // An index beyond the guarded range has no lock bit and is always locked.
  function automatic logic lock_hit(input int unsigned idx,
                                    input int unsigned num_regs,
                                    input logic        lock_bit);
    return (idx >= num_regs) || lock_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reglk_write_guard_if.sv
`default_nettype none
// ============================================================================
// Module      : reglk_write_guard_if
// Description : Bus bundle around the write guard: upstream request/response
//               port (req/we/addr/wdata -> gnt/rvalid/err/rdata) and the
//               downstream port to the register bank (dn_*).
//               slave  : view of the guard itself
//               master : view of the environment (bus master + register bank)
// Revision    : 1.0 - initial release
// ============================================================================
interface reglk_write_guard_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic              err_o;
  logic [DATA_W-1:0] rdata_o;
  logic              dn_req_o;
  logic              dn_we_o;
  logic [ADDR_W-1:0] dn_addr_o;
  logic [DATA_W-1:0] dn_wdata_o;
  logic              dn_gnt_i;
  logic              dn_rvalid_i;
  logic [DATA_W-1:0] dn_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, dn_gnt_i, dn_rvalid_i, dn_rdata_i,
    output gnt_o, rvalid_o, err_o, rdata_o, dn_req_o, dn_we_o, dn_addr_o,
           dn_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, dn_gnt_i, dn_rvalid_i, dn_rdata_i,
    input  gnt_o, rvalid_o, err_o, rdata_o, dn_req_o, dn_we_o, dn_addr_o,
           dn_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
//               clk_i/rst_ni : clock, asynchronous active-low reset
//               inc          : count one event (holds at all-ones)
//               clr          : clear; an event in the same cycle leaves 1
//               cnt_o        : current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] c_max = '1;
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= inc ? c_one : '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/reglk_write_guard.sv
`default_nettype none
// ============================================================================
// Module      : reglk_write_guard
// Description : Blocks bus writes to locked registers. Reads and unlocked
//               writes pass to the register bank unchanged; a write to a
//               locked word is answered with an error, counted and reported.
//               Until the lock source is valid every register is locked.
//               clk_i/rst_ni      : clock, asynchronous active-low reset
//               reglk_i/_valid_i  : lock vector (1 = locked) and its valid
//               bus               : upstream + downstream bus (slave view)
//               viol_clr_i        : clear violation status
//               viol_irq_o        : sticky violation flag
//               viol_cnt_o        : saturating denied-write count
//               viol_addr_o       : first denied address since last clear
// Revision    : 1.0 - initial release
// ============================================================================
module reglk_write_guard
  import reglk_guard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_REGS-1:0] reglk_i,
  input  logic                reglk_valid_i,
  reglk_write_guard_if.slave  bus,
  input  logic                viol_clr_i,
  output logic                viol_irq_o,
  output logic [CNT_W-1:0]    viol_cnt_o,
  output logic [ADDR_W-1:0]   viol_addr_o
);

  localparam int c_idx_w  = ADDR_W - 2;
  localparam int c_lidx_w = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e              r_state;
  state_e              w_state_d;
  logic [NUM_REGS-1:0] r_reglk;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rvalid;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_irq;
  logic [ADDR_W-1:0]   r_viol_addr;
  logic [c_idx_w-1:0]  w_idx;
  logic                w_locked;
  logic                w_accept;
  logic                w_viol;
  logic                w_resp_ok;
  logic                w_fwd;

  // Fail-secure: an invalid lock source locks everything from the next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_reglk <= '1;
    end else begin
      r_reglk <= reglk_valid_i ? reglk_i : '1;
    end
  end

  // Out-of-range indices are resolved by lock_hit before the bit matters.
  assign w_idx    = bus.addr_i[ADDR_W-1:2];
  assign w_locked = lock_hit(32'(w_idx), NUM_REGS,
                             r_reglk[w_idx[c_lidx_w-1:0]]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_viol    = 1'b0;
    w_resp_ok = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_i) begin
          w_accept = 1'b1;
          if (bus.we_i && w_locked) begin
            w_viol    = 1'b1;
            w_state_d = DENY;
          end else begin
            w_state_d = FWD;
          end
        end
      end
      FWD: begin
        if (bus.dn_gnt_i) begin
          // Bank may answer in the grant cycle; skip RESP in that case.
          if (bus.dn_rvalid_i) begin
            w_resp_ok = 1'b1;
            w_state_d = IDLE;
          end else begin
            w_state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.dn_rvalid_i) begin
          w_resp_ok = 1'b1;
          w_state_d = IDLE;
        end
      end
      DENY:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= bus.we_i;
      r_addr  <= bus.addr_i;
      r_wdata <= bus.wdata_i;
    end
  end

  // Single-cycle response; read data stays at the deny fill value when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_resp_ok | w_viol;
      r_err    <= w_viol;
      r_rdata  <= w_resp_ok ? bus.dn_rdata_i : {DATA_W{c_deny_rdata_bit}};
    end
  end

  // A violation in the clear cycle survives the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq       <= 1'b0;
      r_viol_addr <= '0;
    end else begin
      if (w_viol) begin
        r_irq <= 1'b1;
      end else if (viol_clr_i) begin
        r_irq <= 1'b0;
      end
      if (w_viol && (!r_irq || viol_clr_i)) begin
        r_viol_addr <= bus.addr_i;
      end else if (viol_clr_i) begin
        r_viol_addr <= '0;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_viol_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (w_viol),
    .clr    (viol_clr_i),
    .cnt_o  (viol_cnt_o)
  );

  // Downstream fields are zero outside FWD so the bank sees a quiet bus.
  assign w_fwd          = (r_state == FWD);
  assign bus.gnt_o      = w_accept;
  assign bus.rvalid_o   = r_rvalid;
  assign bus.err_o      = r_err;
  assign bus.rdata_o    = r_rdata;
  assign bus.dn_req_o   = w_fwd;
  assign bus.dn_we_o    = w_fwd & r_we;
  assign bus.dn_addr_o  = w_fwd ? r_addr : '0;
  assign bus.dn_wdata_o = w_fwd ? r_wdata : '0;
  assign viol_irq_o     = r_irq;
  assign viol_addr_o    = r_viol_addr;

endmodule
`default_nettype wire

// File: tb/tb_reglk_write_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reglk_write_guard
// Description : Self-checking bench for reglk_write_guard. A reference model
//               tracks the effective lock state and violation status from
//               the stimulus and predicts every response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reglk_write_guard;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] reglk = '0;
  logic        reglk_valid = 1'b0;
  logic        viol_clr = 1'b0;
  logic        viol_irq;
  logic [7:0]  viol_cnt;
  logic [7:0]  viol_addr;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic        m_valid = 1'b0;
  logic [31:0] m_reglk = '0;
  int          m_cnt = 0;
  logic        m_irq = 1'b0;
  logic [7:0]  m_addr = '0;

  // observations of the last access
  logic        g_gnt, g_valid, g_err, g_dn_we;
  logic [31:0] g_rdata, g_dn_wdata;
  logic [7:0]  g_dn_addr;
  int          g_lat, g_dn_cyc;

  always #5 clk = ~clk;

  reglk_write_guard_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reglk_write_guard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .reglk_i       (reglk),
    .reglk_valid_i (reglk_valid),
    .bus           (bus),
    .viol_clr_i    (viol_clr),
    .viol_irq_o    (viol_irq),
    .viol_cnt_o    (viol_cnt),
    .viol_addr_o   (viol_addr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A register is writable only if the lock source is valid, the word exists
  // and its lock bit is clear.
  function automatic logic model_locked(input logic [7:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (!m_valid) return 1'b1;
    if (idx >= NUM_REGS) return 1'b1;
    return m_reglk[idx];
  endfunction

  function automatic logic model_access(input logic we, input logic [7:0] addr,
                                        input logic clr);
    logic deny;
    if (clr) begin
      m_cnt = 0; m_irq = 1'b0; m_addr = '0;
    end
    deny = we && model_locked(addr);
    if (deny) begin
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (!m_irq) m_addr = addr;
      m_irq = 1'b1;
    end
    return deny;
  endfunction

  task automatic set_locks(input logic valid, input logic [31:0] lk);
    @(negedge clk);
    reglk_valid = valid;
    reglk = lk;
    m_valid = valid;
    m_reglk = lk;
  endtask

  // One upstream access; acts as the register bank with the given grant and
  // response delays. Returns at the negedge where rvalid_o was seen.
  task automatic do_access(input logic we, input logic [7:0] addr,
                           input logic [31:0] wd, input logic clr,
                           input int gdly, input int rdly,
                           input logic [31:0] rd);
    int rv_wait;
    g_valid = 0; g_err = 0; g_rdata = '0; g_lat = -1; g_dn_cyc = 0;
    g_dn_we = 0; g_dn_addr = '0; g_dn_wdata = '0; rv_wait = 0;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wd;
    viol_clr = clr;
    #1 g_gnt = bus.gnt_o;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
      viol_clr = 1'b0;
      bus.dn_gnt_i = 1'b0; bus.dn_rvalid_i = 1'b0; bus.dn_rdata_i = '0;
      #1;
      if (bus.rvalid_o) begin
        g_valid = 1'b1; g_err = bus.err_o; g_rdata = bus.rdata_o; g_lat = c;
        break;
      end
      if (bus.dn_req_o) begin
        if (g_dn_cyc == 0) begin
          g_dn_we = bus.dn_we_o; g_dn_addr = bus.dn_addr_o;
          g_dn_wdata = bus.dn_wdata_o;
        end
        g_dn_cyc++;
        if (g_dn_cyc > gdly) begin
          bus.dn_gnt_i = 1'b1;
          if (rdly == 0) begin
            bus.dn_rvalid_i = 1'b1; bus.dn_rdata_i = rd;
          end else begin
            rv_wait = rdly;
          end
        end
      end else if (rv_wait > 0) begin
        rv_wait--;
        if (rv_wait == 0) begin
          bus.dn_rvalid_i = 1'b1; bus.dn_rdata_i = rd;
        end
      end
    end
  endtask

  task automatic test_reset;
    bus.req_i = 0; bus.we_i = 0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.dn_gnt_i = 0; bus.dn_rvalid_i = 0; bus.dn_rdata_i = '0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.gnt_o, bus.rvalid_o, bus.err_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_resp: got %b want 000", {bus.gnt_o, bus.rvalid_o, bus.err_o});
    end
    n_cmp++;
    if (bus.rdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o);
    end
    n_cmp++;
    if ({bus.dn_req_o, bus.dn_we_o, bus.dn_addr_o, bus.dn_wdata_o} !== 42'h0) begin
      n_err++; $display("FAIL reset_dn: got req=%b addr=%h want all 0", bus.dn_req_o, bus.dn_addr_o);
    end
    n_cmp++;
    if ({viol_irq, viol_cnt, viol_addr} !== 17'h0) begin
      n_err++; $display("FAIL reset_viol: got irq=%b cnt=%0d addr=%h want 0", viol_irq, viol_cnt, viol_addr);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_locked_before_valid;
    logic deny;
    set_locks(1'b0, 32'h0);
    deny = model_access(1'b1, 8'h04, 1'b0);
    do_access(1'b1, 8'h04, 32'h1234_5678, 1'b0, 0, 0, 32'h0);
    n_cmp++;
    if ({g_gnt, g_valid, g_err} !== {2'b11, deny}) begin
      n_err++; $display("FAIL prevalid_deny: got gnt/valid/err=%b%b%b want 11%b", g_gnt, g_valid, g_err, deny);
    end
    n_cmp++;
    if (g_lat !== 0 || g_dn_cyc !== 0) begin
      n_err++; $display("FAIL prevalid_timing: got lat=%0d dn=%0d want 0/0", g_lat, g_dn_cyc);
    end
    n_cmp++;
    if (g_rdata !== 32'h0) begin
      n_err++; $display("FAIL prevalid_rdata: got %h want 0", g_rdata);
    end
    n_cmp++;
    if (viol_cnt !== 8'(m_cnt) || viol_addr !== m_addr || viol_irq !== m_irq) begin
      n_err++; $display("FAIL prevalid_viol: got cnt=%0d addr=%h irq=%b want %0d/%h/%b", viol_cnt, viol_addr, viol_irq, m_cnt, m_addr, m_irq);
    end
  endtask

  task automatic test_forward_write;
    logic deny;
    logic [31:0] wd, rd;
    set_locks(1'b1, 32'h0000_0002);
    wd = $urandom; rd = $urandom;
    deny = model_access(1'b1, 8'h08, 1'b0);
    do_access(1'b1, 8'h08, wd, 1'b0, 2, 1, rd);
    n_cmp++;
    if (g_err !== deny || g_valid !== 1'b1) begin
      n_err++; $display("FAIL fwd_err: got valid=%b err=%b want 1/%b", g_valid, g_err, deny);
    end
    n_cmp++;
    if (g_lat !== 4 || g_dn_cyc !== 3) begin
      n_err++; $display("FAIL fwd_timing: got lat=%0d dn=%0d want 4/3", g_lat, g_dn_cyc);
    end
    n_cmp++;
    if ({g_dn_we, g_dn_addr, g_dn_wdata} !== {1'b1, 8'h08, wd}) begin
      n_err++; $display("FAIL fwd_dn_fields: got we=%b addr=%h wd=%h want 1/08/%h", g_dn_we, g_dn_addr, g_dn_wdata, wd);
    end
    n_cmp++;
    if (g_rdata !== rd) begin
      n_err++; $display("FAIL fwd_rdata: got %h want %h", g_rdata, rd);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.rvalid_o !== 1'b0) begin
      n_err++; $display("FAIL fwd_pulse: got rvalid=%b want 0", bus.rvalid_o);
    end
    deny = model_access(1'b1, 8'h04, 1'b0);
    do_access(1'b1, 8'h04, wd, 1'b0, 0, 0, rd);
    n_cmp++;
    if (g_err !== deny || g_dn_cyc !== 0 || g_lat !== 0) begin
      n_err++; $display("FAIL locked_write: got err=%b dn=%0d lat=%0d want %b/0/0", g_err, g_dn_cyc, g_lat, deny);
    end
    n_cmp++;
    if (viol_cnt !== 8'(m_cnt) || viol_addr !== m_addr) begin
      n_err++; $display("FAIL locked_write_viol: got cnt=%0d addr=%h want %0d/%h", viol_cnt, viol_addr, m_cnt, m_addr);
    end
  endtask

  task automatic test_read_locked;
    logic deny;
    deny = model_access(1'b0, 8'h04, 1'b0);
    do_access(1'b0, 8'h04, 32'h0, 1'b0, 0, 0, 32'hCAFE_F00D);
    n_cmp++;
    if ({g_valid, g_err} !== {1'b1, deny} || g_rdata !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL read_locked: got valid=%b err=%b rdata=%h want 1/%b/cafef00d", g_valid, g_err, g_rdata, deny);
    end
    n_cmp++;
    if (g_lat !== 1 || g_dn_we !== 1'b0 || g_dn_addr !== 8'h04) begin
      n_err++; $display("FAIL read_locked_dn: got lat=%0d we=%b addr=%h want 1/0/04", g_lat, g_dn_we, g_dn_addr);
    end
  endtask

  task automatic test_saturation;
    logic deny;
    logic [7:0] a;
    set_locks(1'b1, 32'hFFFF_FFFF);
    deny = model_access(1'b0, 8'h00, 1'b1);
    do_access(1'b0, 8'h00, 32'h0, 1'b1, 0, 0, 32'h5555_AAAA);
    n_cmp++;
    if ({viol_irq, viol_cnt, viol_addr} !== {m_irq, 8'(m_cnt), m_addr}) begin
      n_err++; $display("FAIL clear: got irq=%b cnt=%0d addr=%h want %b/%0d/%h", viol_irq, viol_cnt, viol_addr, m_irq, m_cnt, m_addr);
    end
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      deny = model_access(1'b1, a, 1'b0);
      do_access(1'b1, a, $urandom, 1'b0, 0, 0, 32'h0);
      n_cmp++;
      if (g_err !== deny) begin
        n_err++; $display("FAIL sat_deny[%0d]: got err=%b want %b", i, g_err, deny);
      end
    end
    n_cmp++;
    if (viol_cnt !== 8'(m_cnt) || viol_addr !== m_addr || viol_irq !== 1'b1) begin
      n_err++; $display("FAIL saturate: got cnt=%0d addr=%h irq=%b want %0d/%h/1", viol_cnt, viol_addr, viol_irq, m_cnt, m_addr);
    end
    deny = model_access(1'b1, 8'h10, 1'b1);
    do_access(1'b1, 8'h10, 32'h0, 1'b1, 0, 0, 32'h0);
    n_cmp++;
    if (viol_cnt !== 8'(m_cnt) || viol_addr !== m_addr || g_err !== deny) begin
      n_err++; $display("FAIL clr_with_deny: got cnt=%0d addr=%h err=%b want %0d/%h/%b", viol_cnt, viol_addr, g_err, m_cnt, m_addr, deny);
    end
  endtask

  task automatic test_out_of_range;
    logic deny;
    set_locks(1'b1, 32'h0);
    deny = model_access(1'b0, 8'h00, 1'b1);
    do_access(1'b0, 8'h00, 32'h0, 1'b1, 0, 0, 32'h0);
    deny = model_access(1'b1, 8'h80, 1'b0);
    do_access(1'b1, 8'h80, 32'hDEAD_BEEF, 1'b0, 0, 0, 32'h0);
    n_cmp++;
    if (g_err !== deny || g_dn_cyc !== 0 || viol_addr !== m_addr) begin
      n_err++; $display("FAIL oor_0x80: got err=%b dn=%0d vaddr=%h want %b/0/%h", g_err, g_dn_cyc, viol_addr, deny, m_addr);
    end
    deny = model_access(1'b1, 8'h7C, 1'b0);
    do_access(1'b1, 8'h7C, 32'hDEAD_BEEF, 1'b0, 1, 0, 32'h0);
    n_cmp++;
    if (g_err !== deny || g_dn_cyc !== 2 || g_dn_addr !== 8'h7C) begin
      n_err++; $display("FAIL last_idx_0x7c: got err=%b dn=%0d addr=%h want %b/2/7c", g_err, g_dn_cyc, g_dn_addr, deny);
    end
  endtask

  task automatic test_random;
    logic deny, we, clr;
    logic [7:0] a;
    logic [31:0] wd, rd;
    int gd, rdl, exp_lat;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) set_locks($urandom_range(0, 4) != 0, $urandom);
      we = 1'($urandom); a = 8'($urandom); wd = $urandom; rd = $urandom;
      clr = ($urandom_range(0, 7) == 0);
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      deny = model_access(we, a, clr);
      do_access(we, a, wd, clr, gd, rdl, rd);
      exp_lat = deny ? 0 : gd + rdl + 1;
      n_cmp++;
      if (g_valid !== 1'b1 || g_err !== deny || g_lat !== exp_lat) begin
        n_err++; $display("FAIL rnd_resp[%0d]: got valid=%b err=%b lat=%0d want 1/%b/%0d", i, g_valid, g_err, g_lat, deny, exp_lat);
      end
      n_cmp++;
      if (g_rdata !== (deny ? 32'h0 : rd) || g_dn_cyc !== (deny ? 0 : gd + 1)) begin
        n_err++; $display("FAIL rnd_data[%0d]: got rdata=%h dn=%0d want %h/%0d", i, g_rdata, g_dn_cyc, deny ? 32'h0 : rd, deny ? 0 : gd + 1);
      end
      n_cmp++;
      if (!deny && {g_dn_we, g_dn_addr, g_dn_wdata} !== {we, a, we ? wd : g_dn_wdata}) begin
        n_err++; $display("FAIL rnd_dn[%0d]: got we=%b addr=%h want %b/%h", i, g_dn_we, g_dn_addr, we, a);
      end
      n_cmp++;
      if ({viol_irq, viol_cnt, viol_addr} !== {m_irq, 8'(m_cnt), m_addr}) begin
        n_err++; $display("FAIL rnd_viol[%0d]: got irq=%b cnt=%0d addr=%h want %b/%0d/%h", i, viol_irq, viol_cnt, viol_addr, m_irq, m_cnt, m_addr);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic deny, saw_rvalid;
    set_locks(1'b1, 32'h0);
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 8'h08; bus.wdata_i = 32'h1;
    @(negedge clk);
    bus.req_i = 1'b0; bus.we_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.dn_req_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_fwd: got dn_req=%b want 1", bus.dn_req_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (bus.dn_req_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: got dn_req=%b want 0", bus.dn_req_o);
    end
    saw_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 if (bus.rvalid_o !== 1'b0) saw_rvalid = 1'b1;
    end
    m_cnt = 0; m_irq = 1'b0; m_addr = '0;
    m_valid = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    deny = model_access(1'b1, 8'h08, 1'b0);
    do_access(1'b1, 8'h08, 32'h2, 1'b0, 0, 0, 32'h0);
    if (g_valid !== 1'b1) saw_rvalid = 1'b1;
    n_cmp++;
    if (saw_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_no_rvalid: got stray-or-missing rvalid=%b want 0", saw_rvalid);
    end
    n_cmp++;
    if (g_err !== deny || viol_addr !== m_addr) begin
      n_err++; $display("FAIL rst_relock: got err=%b vaddr=%h want %b/%h", g_err, viol_addr, deny, m_addr);
    end
    m_valid = 1'b1;
    deny = model_access(1'b1, 8'h08, 1'b0);
    do_access(1'b1, 8'h08, 32'h3, 1'b0, 0, 0, 32'h0);
    n_cmp++;
    if (g_err !== deny || g_dn_cyc !== 1) begin
      n_err++; $display("FAIL rst_unlock: got err=%b dn=%0d want %b/1", g_err, g_dn_cyc, deny);
    end
  endtask

  initial begin
    test_reset();
    test_locked_before_valid();
    test_forward_write();
    test_read_locked();
    test_saturation();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
